// File: rtl/c3lib_gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c3lib_gray_pkg
//  Description : Shared Gray-code helpers and parameter limits for the
//                c3lib pointer counters. The converters work on a fixed
//                maximum width; callers zero-extend and truncate to their own
//                width, which is exact because leading zeros map to zeros.
//  Revision    : 1.0  initial release
// ============================================================================
package c3lib_gray_pkg;

    localparam int WIDTH_MIN      = 2;
    localparam int DEC_STAGES_MAX = 2;
    localparam int PTR_W_MAX      = 32;

    typedef logic [PTR_W_MAX-1:0] ptr_t;

    // Binary to reflected Gray code
    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: prefix XOR running down from the MSB
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/c3lib_graytobin.sv
`default_nettype none
// ============================================================================
//  Module      : c3lib_graytobin
//  Description : Purely combinational Gray-to-binary converter of
//                parameterised width. Usable standalone or ahead of a
//                register stage.
//  Revision    : 1.0  initial release
// ============================================================================
module c3lib_graytobin
    import c3lib_gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Zero-extend into the shared converter and keep the low WIDTH bits
    always_comb begin
        o_bin = WIDTH'(gray2bin(ptr_t'(i_gray)));
    end

endmodule
`default_nettype wire

// File: rtl/c3lib_gray_ptr_cntr.sv
`default_nettype none
// ============================================================================
//  Module      : c3lib_gray_ptr_cntr
//  Description : Registered binary/Gray pointer counter with up, down, hold
//                and parallel load, plus a registered Gray-to-binary decode
//                pipeline for the remote (already synchronised) pointer.
//                Binary and Gray registers load from the same next value so
//                the Gray bus leaving the domain never glitches or skews.
//  Revision    : 1.0  initial release
// ============================================================================
module c3lib_gray_ptr_cntr
    import c3lib_gray_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int RST_VAL    = 0,
    parameter int DEC_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic             dec_en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] gray_nxt,
    output logic             wrap_pulse,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_in_dec
);

    // Out-of-range stage counts are clamped to the supported 1..2
    localparam int c_DEC_STAGES = (DEC_STAGES > DEC_STAGES_MAX) ? DEC_STAGES_MAX :
                                  (DEC_STAGES < 1)              ? 1 : DEC_STAGES;

    localparam logic [WIDTH-1:0] c_RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] c_RST_GRAY = c_RST_BIN ^ (c_RST_BIN >> 1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_wrap_nxt;
    logic             w_up;
    logic             w_dn;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] r_dec [c_DEC_STAGES];

    // Next count: load beats count; simultaneous inc and dec cancel to a hold
    always_comb begin
        w_up       = inc_en & ~dec_en;
        w_dn       = dec_en & ~inc_en;
        w_bin_nxt  = r_bin;
        w_wrap_nxt = 1'b0;
        if (load_en) begin
            w_bin_nxt = load_bin;
        end else if (w_up) begin
            w_bin_nxt  = r_bin + WIDTH'(1);
            w_wrap_nxt = (r_bin == {WIDTH{1'b1}});
        end else if (w_dn) begin
            w_bin_nxt  = r_bin - WIDTH'(1);
            w_wrap_nxt = (r_bin == '0);
        end
        w_gray_nxt = WIDTH'(bin2gray(ptr_t'(w_bin_nxt)));
    end

    // Count, Gray image and wrap flag all register the same next value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= c_RST_BIN;
            r_gray <= c_RST_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    c3lib_graytobin #(
        .WIDTH (WIDTH)
    ) u_graytobin (
        .i_gray (gray_in),
        .o_bin  (w_dec)
    );

    // Remote decode pipeline, free-running regardless of the count enables
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEC_STAGES; i++) begin
                r_dec[i] <= '0;
            end
        end else begin
            r_dec[0] <= w_dec;
            for (int i = 1; i < c_DEC_STAGES; i++) begin
                r_dec[i] <= r_dec[i-1];
            end
        end
    end

    assign bin_out    = r_bin;
    assign gray_out   = r_gray;
    assign gray_nxt   = w_gray_nxt;
    assign wrap_pulse = r_wrap;
    assign bin_in_dec = r_dec[c_DEC_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_c3lib_gray_ptr_cntr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c3lib_gray_ptr_cntr
//  Description : Self-checking bench. u4: WIDTH=4, RST_VAL=0, DEC_STAGES=2.
//                u6: WIDTH=6, RST_VAL=9, DEC_STAGES=1. Expected results are
//                queued when stimulus is driven and popped after the edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_c3lib_gray_ptr_cntr;

    typedef struct {
        int bin;
        int gray;
        bit wrap;
        int mode;   // 0 load/reset, 1 single step, 2 hold
    } exp_t;

    logic       clk = 1'b0;
    logic       rst4, inc4, dec4, ld4;
    logic [3:0] lb4, gi4;
    logic [3:0] bin4, gray4, gnxt4, bdec4;
    logic       wrap4;
    logic       rst6, inc6, dec6, ld6;
    logic [5:0] lb6, gi6;
    logic [5:0] bin6, gray6, gnxt6, bdec6;
    logic       wrap6;

    int   checks = 0;
    int   errors = 0;
    int   m4 = 0;
    int   m6 = 9;
    exp_t q4[$];
    exp_t q6[$];
    int   dq4[$];
    int   dq6[$];
    int   gt[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 9, 8};

    always #5 clk = ~clk;

    c3lib_gray_ptr_cntr #(.WIDTH(4), .RST_VAL(0), .DEC_STAGES(2)) u4 (
        .clk(clk), .rst(rst4), .inc_en(inc4), .dec_en(dec4), .load_en(ld4),
        .load_bin(lb4), .bin_out(bin4), .gray_out(gray4), .gray_nxt(gnxt4),
        .wrap_pulse(wrap4), .gray_in(gi4), .bin_in_dec(bdec4)
    );

    c3lib_gray_ptr_cntr #(.WIDTH(6), .RST_VAL(9), .DEC_STAGES(1)) u6 (
        .clk(clk), .rst(rst6), .inc_en(inc6), .dec_en(dec6), .load_en(ld6),
        .load_bin(lb6), .bin_out(bin6), .gray_out(gray6), .gray_nxt(gnxt6),
        .wrap_pulse(wrap6), .gray_in(gi6), .bin_in_dec(bdec6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int nxt_bin(int w, int rv, int b, bit inc, bit dec, bit ld, int lb, bit r);
        int m = (1 << w) - 1;
        if (r) return rv;
        if (ld) return lb & m;
        if (inc && !dec) return (b + 1) & m;
        if (dec && !inc) return (b - 1) & m;
        return b;
    endfunction

    function automatic bit nxt_wrap(int w, int b, bit inc, bit dec, bit ld, bit r);
        if (r || ld) return 1'b0;
        if (inc && !dec) return b == ((1 << w) - 1);
        if (dec && !inc) return b == 0;
        return 1'b0;
    endfunction

    // Reference decode by search: the b whose Gray image is g
    function automatic int g2b_ref(int w, int g);
        for (int b = 0; b < (1 << w); b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    function automatic exp_t mk(int w, int rv, int b, bit inc, bit dec, bit ld, int lb, bit r);
        exp_t e;
        e.bin  = nxt_bin(w, rv, b, inc, dec, ld, lb, r);
        e.gray = e.bin ^ (e.bin >> 1);
        e.wrap = nxt_wrap(w, b, inc, dec, ld, r);
        e.mode = (r || ld) ? 0 : ((inc ^ dec) ? 1 : 2);
        return e;
    endfunction

    task automatic cmp_cntr(input string p, input exp_t e, input logic [31:0] b,
                            input logic [31:0] g, input logic wr, input logic [31:0] pg);
        chk({p, "_bin"},  b, 32'(e.bin));
        chk({p, "_gray"}, g, 32'(e.gray));
        chk({p, "_wrap"}, 32'(wr), 32'(e.wrap));
        chk({p, "_inv"},  g, b ^ (b >> 1));
        if (e.mode == 1) chk({p, "_onebit"}, 32'($countones(pg ^ g)), 1);
        if (e.mode == 2) chk({p, "_hold"},   32'($countones(pg ^ g)), 0);
    endtask

    task automatic cmp_dec(input string p, inout int dq[$], input logic [31:0] obs);
        if (dq.size() == 0) begin
            chk({p, "_dq_empty"}, obs, 32'hFFFF_FFFF);
        end else begin
            chk({p, "_dec"}, obs, 32'(dq.pop_front()));
        end
    endtask

    // One clock: queue expectations, check gray_nxt mid-cycle, check outputs after edge
    task automatic tick();
        exp_t e4, e6;
        logic [31:0] pg4, pg6;
        e4 = mk(4, 0, m4, inc4, dec4, ld4, int'(lb4), rst4);
        e6 = mk(6, 9, m6, inc6, dec6, ld6, int'(lb6), rst6);
        q4.push_back(e4);
        q6.push_back(e6);
        if (rst4) begin
            dq4.delete();
            repeat (2) dq4.push_back(0);
        end else begin
            dq4.push_back(g2b_ref(4, int'(gi4)));
        end
        if (rst6) begin
            dq6.delete();
            dq6.push_back(0);
        end else begin
            dq6.push_back(g2b_ref(6, int'(gi6)));
        end
        m4 = e4.bin;
        m6 = e6.bin;
        @(negedge clk);
        pg4 = 32'(gray4);
        pg6 = 32'(gray6);
        if (!rst4) chk("u4_gnxt", 32'(gnxt4), 32'(e4.gray));
        if (!rst6) chk("u6_gnxt", 32'(gnxt6), 32'(e6.gray));
        @(posedge clk);
        #1;
        cmp_cntr("u4", q4.pop_front(), 32'(bin4), 32'(gray4), wrap4, pg4);
        cmp_cntr("u6", q6.pop_front(), 32'(bin6), 32'(gray6), wrap6, pg6);
        cmp_dec("u4", dq4, 32'(bdec4));
        cmp_dec("u6", dq6, 32'(bdec6));
    endtask

    initial begin
        rst4 = 1'b1; inc4 = 1'b0; dec4 = 1'b0; ld4 = 1'b0; lb4 = '0; gi4 = '0;
        rst6 = 1'b1; inc6 = 1'b0; dec6 = 1'b0; ld6 = 1'b0; lb6 = '0; gi6 = '0;
        @(posedge clk);
        #1;
        repeat (2) tick();
        chk("rst4_bin", 32'(bin4), 0);
        chk("rst6_bin", 32'(bin6), 9);
        chk("rst6_gray", 32'(gray6), 'hD);

        // Full up-count with wrap
        rst4 = 1'b0; rst6 = 1'b0; inc4 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("inc_gtab", 32'(gray4), 32'(gt[i % 16]));
            chk("inc_wrap", 32'(wrap4), 32'(i == 16));
        end

        // Down through zero
        inc4 = 1'b0; dec4 = 1'b1;
        tick();
        chk("dn1_bin", 32'(bin4), 'hF); chk("dn1_gray", 32'(gray4), 8); chk("dn1_wrap", 32'(wrap4), 1);
        tick();
        chk("dn2_bin", 32'(bin4), 'hE); chk("dn2_gray", 32'(gray4), 9); chk("dn2_wrap", 32'(wrap4), 0);

        // Load 5, then inc+dec holds, then load beats inc
        dec4 = 1'b0; ld4 = 1'b1; lb4 = 4'h5;
        tick();
        ld4 = 1'b0; inc4 = 1'b1; dec4 = 1'b1;
        tick();
        chk("hold_bin", 32'(bin4), 5); chk("hold_gray", 32'(gray4), 7);
        dec4 = 1'b0; ld4 = 1'b1; lb4 = 4'hA;
        tick();
        chk("ld_bin", 32'(bin4), 'hA); chk("ld_gray", 32'(gray4), 'hF); chk("ld_wrap", 32'(wrap4), 0);
        inc4 = 1'b0; ld4 = 1'b0;

        // Two-stage remote decode latency
        gi4 = 4'h8;
        tick();
        gi4 = 4'hB;
        tick();
        chk("dec_8", 32'(bdec4), 'hF);
        tick();
        chk("dec_B", 32'(bdec4), 'hD);

        // u6 count 9 -> C, then reset wins over inc
        gi6 = 6'h3;
        inc6 = 1'b1;
        repeat (3) tick();
        chk("u6_c", 32'(bin6), 'hC);
        rst6 = 1'b1;
        tick();
        chk("u6_rst_bin", 32'(bin6), 9); chk("u6_rst_gray", 32'(gray6), 'hD);
        chk("u6_rst_wrap", 32'(wrap6), 0); chk("u6_rst_dec", 32'(bdec6), 0);
        rst6 = 1'b0; inc6 = 1'b0;

        // Random stimulus on both instances
        for (int n = 0; n < 10000; n++) begin
            rst4 = ($urandom_range(63) == 0); ld4 = ($urandom_range(9) == 0);
            inc4 = 1'($urandom); dec4 = 1'($urandom);
            lb4 = 4'($urandom); gi4 = 4'($urandom);
            rst6 = ($urandom_range(63) == 0); ld6 = ($urandom_range(9) == 0);
            inc6 = 1'($urandom); dec6 = 1'($urandom);
            lb6 = 6'($urandom); gi6 = 6'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
